// File: rtl/fft_pkg.sv
// Shared definitions for the streaming FFT stage chain.
//   rd_state_e : read-side FSM states of the bit-reverse reorder buffer
//   cplx_t     : packed complex sample at the final-stage output width
//   log2n()    : address width for an N-point frame
//   bitrev()   : reverses the low 'bits' bits of a value
package fft_pkg;

  // Final-stage output width of the FFT chain; cplx_t is sized by it.
  localparam int CPLX_W = 17;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  function automatic int log2n(input int n);
    return $clog2(n);
  endfunction

  // Only the low 'bits' bits are reversed; higher bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int bits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < bits; i++) begin
      r[i] = v[bits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pp_ram.sv
// Simple dual-port RAM backing the ping-pong reorder buffer.
// Write is gated by clk_en; read data is registered and holds its value
// whenever no read is issued (or clk_en is low).
//   clk, rst_n, clk_en : clock, async active-low reset (read register only), enable
//   we, waddr, wdata   : write port
//   re, raddr, rdata   : read port, rdata valid the cycle after re
module fft_pp_ram #(
  parameter int DW = 34,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_en,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Storage array is deliberately not reset so it maps onto RAM macros.
  always_ff @(posedge clk) begin
    if (clk_en && we) begin
      mem[waddr] <= wdata;
    end
  end

  // The read register doubles as the block's output data register, so it
  // carries the reset value of o_real/o_imag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (clk_en && re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Bit-reverse to natural-order reorder buffer at the end of the FFT chain.
// Frames arrive in bit-reversed order (i_valid qualified, no backpressure)
// and leave in natural order. One bank of a 2*N ping-pong buffer fills while
// the other drains.
//
// Optional build macro: FFT_REORDER_FRAME_MARK_EN adds o_sop/o_eop frame
// markers aligned with o_valid.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   clk_en            : global enable, freezes all state when low
//   i_flush           : synchronous flush of all buffered/partial frames
//   i_valid, i_real, i_imag : input samples, bit-reversed order
//   o_valid, o_real, o_imag : output samples, natural order
//   o_sop, o_eop      : (macro only) first / last sample of a frame
//
// state | meaning
// IDLE  | waiting for the read bank to be full
// READ  | draining the read bank, one sample per cycle
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int N     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             i_flush,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_real,
  input  logic [WIDTH-1:0] i_imag,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_real,
  output logic [WIDTH-1:0] o_imag
`ifdef FFT_REORDER_FRAME_MARK_EN
  ,
  output logic             o_sop,
  output logic             o_eop
`endif
);

  localparam int LW = log2n(N);
  localparam int AW = LW + 1;
  localparam logic [LW-1:0] LAST_IDX = LW'(N - 1);

  rd_state_e     state, state_nxt;
  logic [LW-1:0] wr_idx, wr_idx_nxt;
  logic [LW-1:0] rd_idx, rd_idx_nxt;
  logic          wr_bank, wr_bank_nxt;
  logic          rd_bank, rd_bank_nxt;
  logic [1:0]    full, full_nxt;
  logic          rd_issue;
  logic          wr_en;
  logic [AW-1:0] waddr, raddr;
  logic [LW-1:0] rd_idx_rev;
  logic [2*WIDTH-1:0] rd_data;

  always_comb begin
    state_nxt   = state;
    wr_idx_nxt  = wr_idx;
    wr_bank_nxt = wr_bank;
    rd_idx_nxt  = rd_idx;
    rd_bank_nxt = rd_bank;
    full_nxt    = full;
    rd_issue    = 1'b0;

    if (i_flush) begin
      state_nxt   = IDLE;
      wr_idx_nxt  = '0;
      wr_bank_nxt = 1'b0;
      rd_idx_nxt  = '0;
      rd_bank_nxt = 1'b0;
      full_nxt    = '0;
    end else begin
      if (i_valid) begin
        wr_idx_nxt = wr_idx + 1'b1;
        if (wr_idx == LAST_IDX) begin
          full_nxt[wr_bank] = 1'b1;
          wr_bank_nxt       = ~wr_bank;
          wr_idx_nxt        = '0;
        end
      end

      // Read-side update comes after the write side so that a clear of the
      // same bank wins over a set.
      case (state)
        IDLE: begin
          if (full[rd_bank]) begin
            state_nxt  = READ;
            rd_idx_nxt = '0;
          end
        end
        READ: begin
          rd_issue   = 1'b1;
          rd_idx_nxt = rd_idx + 1'b1;
          if (rd_idx == LAST_IDX) begin
            full_nxt[rd_bank] = 1'b0;
            rd_bank_nxt       = ~rd_bank;
            rd_idx_nxt        = '0;
            if (!full[~rd_bank]) begin
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_idx  <= '0;
      wr_bank <= 1'b0;
      rd_idx  <= '0;
      rd_bank <= 1'b0;
      full    <= '0;
      o_valid <= 1'b0;
    end else if (clk_en) begin
      state   <= state_nxt;
      wr_idx  <= wr_idx_nxt;
      wr_bank <= wr_bank_nxt;
      rd_idx  <= rd_idx_nxt;
      rd_bank <= rd_bank_nxt;
      full    <= full_nxt;
      o_valid <= rd_issue;
    end
  end

`ifdef FFT_REORDER_FRAME_MARK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_sop <= 1'b0;
      o_eop <= 1'b0;
    end else if (clk_en) begin
      o_sop <= rd_issue && (rd_idx == '0);
      o_eop <= rd_issue && (rd_idx == LAST_IDX);
    end
  end
`endif

  // A sample in the flush cycle is dropped, not written.
  assign wr_en      = i_valid && !i_flush;
  assign waddr      = {wr_bank, wr_idx};
  assign rd_idx_rev = LW'(bitrev(32'(rd_idx), LW));
  assign raddr      = {rd_bank, rd_idx_rev};

  fft_pp_ram #(
    .DW (2 * WIDTH),
    .AW (AW)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .we     (wr_en),
    .waddr  (waddr),
    .wdata  ({i_real, i_imag}),
    .re     (rd_issue),
    .raddr  (raddr),
    .rdata  (rd_data)
  );

  assign o_real = rd_data[2*WIDTH-1:WIDTH];
  assign o_imag = rd_data[WIDTH-1:0];

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;

  localparam int WIDTH = 17;
  localparam int N     = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clk_en = 1'b0;
  logic             i_flush = 1'b0;
  logic             i_valid = 1'b0;
  logic [WIDTH-1:0] i_real = '0;
  logic [WIDTH-1:0] i_imag = '0;
  logic             o_valid;
  logic [WIDTH-1:0] o_real;
  logic [WIDTH-1:0] o_imag;
`ifdef FFT_REORDER_FRAME_MARK_EN
  logic             o_sop;
  logic             o_eop;
`endif

  fft_bitrev_reorder #(.WIDTH(WIDTH), .N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_en  (clk_en),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .i_real  (i_real),
    .i_imag  (i_imag),
    .o_valid (o_valid),
    .o_real  (o_real),
    .o_imag  (o_imag)
`ifdef FFT_REORDER_FRAME_MARK_EN
    ,
    .o_sop   (o_sop),
    .o_eop   (o_eop)
`endif
  );

  always #5 clk = ~clk;

  // Natural-order output index k takes the input at position perm[k].
  int perm [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

  typedef struct {
    logic [WIDTH-1:0] re;
    logic [WIDTH-1:0] im;
    int               idx;
  } exp_t;

  exp_t exp_q[$];
  int   out_cyc[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic en_seen = 1'b0;
  logic             prev_valid = 1'b0;
  logic [WIDTH-1:0] prev_real = '0;
  logic [WIDTH-1:0] prev_imag = '0;

  function automatic logic [WIDTH-1:0] im_of(input int v);
    return WIDTH'(v * 3 + 5);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    en_seen <= clk_en;
    if (clk_en) cyc <= cyc + 1;
  end

  // Monitor: checks outputs after every enabled edge, and checks that
  // outputs stay frozen across disabled edges.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (!en_seen) begin
        check("frozen_valid", 64'(o_valid), 64'(prev_valid));
        check("frozen_real", 64'(o_real), 64'(prev_real));
        check("frozen_imag", 64'(o_imag), 64'(prev_imag));
      end else if (o_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got o_real=%0d, expected no output (t=%0t)", o_real, $time);
        end else begin
          e = exp_q.pop_front();
          check("out_real", 64'(o_real), 64'(e.re));
          check("out_imag", 64'(o_imag), 64'(e.im));
`ifdef FFT_REORDER_FRAME_MARK_EN
          check("out_sop", 64'(o_sop), 64'(e.idx == 0));
          check("out_eop", 64'(o_eop), 64'(e.idx == N - 1));
`endif
          out_cyc.push_back(cyc);
        end
      end
`ifdef FFT_REORDER_FRAME_MARK_EN
      else if (en_seen) begin
        check("sop_idle", 64'(o_sop), 64'(0));
        check("eop_idle", 64'(o_eop), 64'(0));
      end
`endif
    end
    prev_valid <= o_valid;
    prev_real  <= o_real;
    prev_imag  <= o_imag;
  end

  task automatic push_frame(input int base);
    for (int k = 0; k < N; k++) begin
      exp_q.push_back('{re: WIDTH'(base + perm[k]), im: im_of(base + perm[k]), idx: k});
    end
  endtask

  task automatic send(input logic v, input int d, input logic en, input logic fl);
    clk_en  = en;
    i_valid = v;
    i_flush = fl;
    i_real  = WIDTH'(d);
    i_imag  = im_of(d);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    clk_en = 1'b1;
    while (exp_q.size() > 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(name, 64'(exp_q.size()), 64'(0));
    repeat (6) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int last_cap;
    int cnt;
    int frames;
    int iter;
    logic v;
    logic en;

    // Reset values
    #12;
    check("reset_valid", 64'(o_valid), 64'(0));
    check("reset_real", 64'(o_real), 64'(0));
    check("reset_imag", 64'(o_imag), 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clk_en = 1'b1;

    // Single frame 0..7, latency and contiguity
    out_cyc.delete();
    push_frame(0);
    for (int i = 0; i < N; i++) send(1'b1, i, 1'b1, 1'b0);
    last_cap = cyc;
    wait_drain("drain_single");
    check("single_count", 64'(out_cyc.size()), 64'(N));
    if (out_cyc.size() == N) begin
      check("single_latency", 64'(out_cyc[0]), 64'(last_cap + 2));
      check("single_last", 64'(out_cyc[N-1]), 64'(last_cap + 9));
    end

    // Three back-to-back frames 0..23
    out_cyc.delete();
    push_frame(0);
    push_frame(8);
    push_frame(16);
    for (int i = 0; i < 3 * N; i++) send(1'b1, i, 1'b1, 1'b0);
    wait_drain("drain_b2b");
    check("b2b_count", 64'(out_cyc.size()), 64'(3 * N));
    if (out_cyc.size() == 3 * N) begin
      check("b2b_no_gap", 64'(out_cyc[3*N-1] - out_cyc[0]), 64'(3 * N - 1));
    end

    // Random i_valid and clk_en, 10 frames of consecutive values from 1000
    cnt = 0;
    frames = 0;
    iter = 0;
    while (frames < 10 && iter < 3000) begin
      en = ($urandom_range(0, 3) != 0);
      v  = ($urandom_range(0, 1) == 1);
      if (en && v) begin
        cnt++;
        if (cnt == N) begin
          push_frame(1000 + frames * N);
          frames++;
          cnt = 0;
        end
      end
      send(v, 1000 + frames * N + (en && v ? (cnt == 0 ? -1 + N - N + (N - 1) - (N - 1) + (N - 1) - (N - 1) : cnt - 1) : cnt), en, 1'b0);
      iter++;
    end
    check("random_frames", 64'(frames), 64'(10));
    wait_drain("drain_random");

    // Flush after 5 samples, then frame 100..107
    for (int i = 0; i < 5; i++) send(1'b1, 50 + i, 1'b1, 1'b0);
    send(1'b1, 55, 1'b1, 1'b1);
    push_frame(100);
    for (int i = 0; i < N; i++) send(1'b1, 100 + i, 1'b1, 1'b0);
    wait_drain("drain_flush");

    // Async reset while streaming, then a fresh frame
    out_cyc.delete();
    push_frame(300);
    for (int i = 0; i < N; i++) send(1'b1, 300 + i, 1'b1, 1'b0);
    iter = 0;
    while (out_cyc.size() < 3 && iter < 50) begin
      @(posedge clk);
      #1;
      iter++;
    end
    check("reset_stream_started", 64'(out_cyc.size() >= 3), 64'(1));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_valid", 64'(o_valid), 64'(0));
    check("async_reset_real", 64'(o_real), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_frame(400);
    for (int i = 0; i < N; i++) send(1'b1, 400 + i, 1'b1, 1'b0);
    wait_drain("drain_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
